// File: rtl/serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder.
// The DUT uses the slave modport and the requester uses the master modport.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_c;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_s;
    logic             o_c;

    modport master (
        output i_start, i_a, i_b, i_c,
        input  o_busy, o_done, o_s, o_c
    );

    modport slave (
        input  i_start, i_a, i_b, i_c,
        output o_busy, o_done, o_s, o_c
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flip-flop, LSB first.
// It processes one bit per clock and has a start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    serial_adder_if.slave   bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             done_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sum_next;

    // Single full-adder cell working on the current LSBs and the stored carry.
    always_comb begin
        fa_s     = a_sr[0] ^ b_sr[0] ^ carry;
        fa_c     = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        sum_next = {fa_s, sum_sr[WIDTH-1:1]};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            done_q <= 1'b0;
            s_q    <= '0;
            c_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        a_sr   <= bus.i_a;
                        b_sr   <= bus.i_b;
                        carry  <= bus.i_c;
                        sum_sr <= '0;
                        cnt    <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_next;
                    carry  <= fa_c;
                    // The last bit goes straight to the outputs, so o_s never shows partial sums.
                    if (cnt == LAST_CNT) begin
                        s_q    <= sum_next;
                        c_q    <= fa_c;
                        done_q <= 1'b1;
                        cnt    <= '0;
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_busy = (state == ST_RUN);
    assign bus.o_done = done_q;
    assign bus.o_s    = s_q;
    assign bus.o_c    = c_q;
endmodule
